stopwatch_display_scan: RTL and testbench

Display back-end that sits directly downstream of the stopwatch counter. It snapshots minute/second/float_second and converts seconds to two BCD digits with a small sequential divider. It time-multiplexes the four digits onto the active-low 7-segment bus (AN/out/dot). It also adds a lap-freeze function driven by a one-pulse input.

---
 rtl/stopwatch_display_scan_pkg.sv | 43 ++++
 rtl/stopwatch_display_scan_bcd_seg_enc.sv | 28 ++
 rtl/stopwatch_display_scan.sv | 197 +++++++++++++++++++
 tb/tb_stopwatch_display_scan.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_display_scan_pkg.sv
// Shared constants for the stopwatch display back-end: segment codes, digit
// enables and the seconds-to-BCD converter state encoding.
package stopwatch_disp_pkg;

  // Segment patterns, bit order a..g, active low.
  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_DASH  = 7'b1111110;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  function automatic logic [3:0] an_for_sel(input logic [1:0] sel);
    logic [3:0] an;
    case (sel)
      2'd0:    an = AN_DIG0;
      2'd1:    an = AN_DIG1;
      2'd2:    an = AN_DIG2;
      2'd3:    an = AN_DIG3;
      default: an = AN_OFF;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/stopwatch_display_scan_bcd_seg_enc.sv
// Combinational BCD digit to active-low 7-segment encoder; values above 9
// render as a dash so bad upstream data is visible rather than aliased.
module bcd_seg_enc
  import stopwatch_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [0:6] seg
);

  // Digit lookup with dash fallback.
  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_display_scan.sv
// Four-digit multiplexed 7-segment scan with snapshot, seconds-to-BCD divider
// and lap freeze. Optional leading-zero blanking: STOPWATCH_LEAD_BLANK_EN.
module stopwatch_display_scan
  import stopwatch_disp_pkg::*;
#(
  parameter int DWELL   = 1,
  parameter int DOT_POS = 1
) (
  input  logic       divided_clk_display,
  input  logic       reset,
  input  logic [3:0] minute,
  input  logic [5:0] second,
  input  logic [3:0] float_second,
  input  logic       lap,
  output logic [3:0] AN,
  output logic [0:6] out,
  output logic       dot,
  output logic       frozen
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [1:0] DOT_SEL    = 2'(DOT_POS);

  logic [7:0]  dwell_cnt_r;
  logic [1:0]  sel_r;
  logic        frozen_r;
  logic [3:0]  snap_minute_r;
  logic [3:0]  snap_float_r;
  logic [5:0]  snap_second_r;
  logic        conv_start_r;
  conv_state_e state_r, state_s;
  logic [5:0]  rem_r, rem_s;
  logic [3:0]  tens_r, tens_s;
  logic [3:0]  sec_tens_r, sec_tens_s;
  logic [3:0]  sec_ones_r, sec_ones_s;
  logic [3:0]  an_r;
  logic [0:6]  out_r;
  logic        dot_r;

  logic        dwell_end_s;
  logic        wrap_s;
  logic        snap_en_s;
  logic [3:0]  digit_s;
  logic        blank_s;
  logic [0:6]  enc_seg_s;
  logic [0:6]  seg_s;

  assign dwell_end_s = (dwell_cnt_r == DWELL_LAST);
  assign wrap_s      = dwell_end_s && (sel_r == 2'd3);
  // A lap that freezes blocks this wrap; an unfreezing lap still sees frozen_r=1.
  assign snap_en_s   = wrap_s && !frozen_r && !lap;

  // Dwell counter and digit select.
  always_ff @(posedge divided_clk_display) begin
    if (!reset) begin
      dwell_cnt_r <= 8'd0;
      sel_r       <= 2'd0;
    end else if (dwell_end_s) begin
      dwell_cnt_r <= 8'd0;
      sel_r       <= sel_r + 2'd1;
    end else begin
      dwell_cnt_r <= dwell_cnt_r + 8'd1;
    end
  end

  // Lap freeze flag.
  always_ff @(posedge divided_clk_display) begin
    if (!reset) begin
      frozen_r <= 1'b0;
    end else if (lap) begin
      frozen_r <= !frozen_r;
    end else begin
      frozen_r <= frozen_r;
    end
  end

  // Snapshot of the counter at the end of each full scan.
  always_ff @(posedge divided_clk_display) begin
    if (!reset) begin
      snap_minute_r <= 4'd0;
      snap_float_r  <= 4'd0;
      snap_second_r <= 6'd0;
      conv_start_r  <= 1'b0;
    end else begin
      conv_start_r <= snap_en_s;
      if (snap_en_s) begin
        snap_minute_r <= minute;
        snap_float_r  <= float_second;
        snap_second_r <= second;
      end
    end
  end

  // Converter state and working registers.
  always_ff @(posedge divided_clk_display) begin
    if (!reset) begin
      state_r    <= IDLE;
      rem_r      <= 6'd0;
      tens_r     <= 4'd0;
      sec_tens_r <= 4'd0;
      sec_ones_r <= 4'd0;
    end else begin
      state_r    <= state_s;
      rem_r      <= rem_s;
      tens_r     <= tens_s;
      sec_tens_r <= sec_tens_s;
      sec_ones_r <= sec_ones_s;
    end
  end

  // Repeated-subtraction divide by ten; display BCD only written in DONE.
  always_comb begin
    state_s    = state_r;
    rem_s      = rem_r;
    tens_s     = tens_r;
    sec_tens_s = sec_tens_r;
    sec_ones_s = sec_ones_r;
    case (state_r)
      IDLE: begin
        if (conv_start_r) begin
          rem_s   = snap_second_r;
          tens_s  = 4'd0;
          state_s = SUB;
        end else begin
          state_s = IDLE;
        end
      end
      SUB: begin
        if (rem_r >= 6'd10) begin
          rem_s  = rem_r - 6'd10;
          tens_s = tens_r + 4'd1;
        end else begin
          state_s = DONE;
        end
      end
      DONE: begin
        sec_tens_s = tens_r;
        sec_ones_s = rem_r[3:0];
        state_s    = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Digit mux with optional leading-zero blanking.
  always_comb begin
    digit_s = 4'd0;
    blank_s = 1'b0;
    case (sel_r)
      2'd0: digit_s = snap_float_r;
      2'd1: digit_s = sec_ones_r;
      2'd2: begin
        digit_s = sec_tens_r;
`ifdef STOPWATCH_LEAD_BLANK_EN
        blank_s = (snap_minute_r == 4'd0) && (sec_tens_r == 4'd0);
`else
        blank_s = 1'b0;
`endif
      end
      2'd3: begin
        digit_s = snap_minute_r;
`ifdef STOPWATCH_LEAD_BLANK_EN
        blank_s = (snap_minute_r == 4'd0);
`else
        blank_s = 1'b0;
`endif
      end
      default: digit_s = 4'd0;
    endcase
  end

  bcd_seg_enc u_enc (
    .digit (digit_s),
    .seg   (enc_seg_s)
  );

  assign seg_s = blank_s ? SEG_BLANK : enc_seg_s;

  // Registered pin drivers, one cycle behind sel.
  always_ff @(posedge divided_clk_display) begin
    if (!reset) begin
      an_r  <= AN_OFF;
      out_r <= SEG_BLANK;
      dot_r <= 1'b1;
    end else begin
      an_r  <= an_for_sel(sel_r);
      out_r <= seg_s;
      dot_r <= (sel_r == DOT_SEL) ? 1'b0 : 1'b1;
    end
  end

  assign AN     = an_r;
  assign out    = out_r;
  assign dot    = dot_r;
  assign frozen = frozen_r;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Directed self-checking bench for stopwatch_display_scan (DWELL=1, DOT_POS=1);
// blanking expectations follow STOPWATCH_LEAD_BLANK_EN.
module tb_stopwatch_display_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] minute;
  logic [5:0] second;
  logic [3:0] float_second;
  logic       lap;
  logic [3:0] AN;
  logic [0:6] out;
  logic       dot;
  logic       frozen;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stopwatch_display_scan #(.DWELL(1), .DOT_POS(1)) dut (
    .divided_clk_display (clk),
    .reset               (reset),
    .minute              (minute),
    .second              (second),
    .float_second        (float_second),
    .lap                 (lap),
    .AN                  (AN),
    .out                 (out),
    .dot                 (dot),
    .frozen              (frozen)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, want);
    end
  endtask

  task automatic chk_reset_pins(input string tag);
    chk({tag, "_an"},     8'(AN),     8'b00001111);
    chk({tag, "_out"},    8'(out),    8'b01111111);
    chk({tag, "_dot"},    8'(dot),    8'd1);
    chk({tag, "_frozen"}, 8'(frozen), 8'd0);
  endtask

  // Wait (bounded) for a digit enable, then check its segments and dot.
  task automatic show(input string tag, input logic [3:0] an_want,
                      input logic [6:0] seg_want, input logic dot_want);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (AN === an_want) found = 1'b1;
    end
    chk({tag, "_an_seen"}, 8'(found), 8'd1);
    if (found) begin
      chk({tag, "_out"}, 8'(out), 8'(seg_want));
      chk({tag, "_dot"}, 8'(dot), 8'(dot_want));
    end
  endtask

  initial begin
    logic seen0;
    logic ok;

    // Reset held for three cycles.
    reset = 1'b0; minute = 4'd5; second = 6'd37; float_second = 4'd4; lap = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_reset_pins("reset_hold");
    end

    // First cycle after release shows digit 0 with a zero snapshot.
    reset = 1'b1;
    tick();
    chk("release_an",  8'(AN),  8'b00001110);
    chk("release_out", 8'(out), 8'b00000001);
    chk("release_dot", 8'(dot), 8'd1);

    // 3:59.7
    minute = 4'd3; second = 6'd59; float_second = 4'd7;
    repeat (16) tick();
    show("d359_tenths", 4'b1110, 7'b0001111, 1'b1);
    show("d359_ones",   4'b1101, 7'b0000100, 1'b0);
    show("d359_tens",   4'b1011, 7'b0100100, 1'b1);
    show("d359_min",    4'b0111, 7'b0000110, 1'b1);

    // 59 -> 0 mid-conversion: only 5/9 then 0/0 may appear.
    tick();
    second = 6'd0;
    seen0 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (AN === 4'b1011) begin
        ok = (out === 7'b0000001) || ((out === 7'b0100100) && !seen0);
        if (out === 7'b0000001) seen0 = 1'b1;
        chk("atomic_tens", 8'(ok), 8'd1);
      end
      if (AN === 4'b1101) begin
        ok = (out === 7'b0000001) || ((out === 7'b0000100) && !seen0);
        if (out === 7'b0000001) seen0 = 1'b1;
        chk("atomic_ones", 8'(ok), 8'd1);
      end
    end
    show("d300_ones", 4'b1101, 7'b0000001, 1'b0);
    show("d300_tens", 4'b1011, 7'b0000001, 1'b1);

    // Freeze, change inputs, display must hold 3:00.7.
    lap = 1'b1;
    tick();
    lap = 1'b0;
    chk("lap1_frozen", 8'(frozen), 8'd1);
    minute = 4'd4; second = 6'd12; float_second = 4'd0;
    repeat (20) tick();
    chk("hold_frozen", 8'(frozen), 8'd1);
    show("hold_tenths", 4'b1110, 7'b0001111, 1'b1);
    show("hold_ones",   4'b1101, 7'b0000001, 1'b0);
    show("hold_tens",   4'b1011, 7'b0000001, 1'b1);
    show("hold_min",    4'b0111, 7'b0000110, 1'b1);

    // Unfreeze, 4:12.0 appears.
    lap = 1'b1;
    tick();
    lap = 1'b0;
    chk("lap2_frozen", 8'(frozen), 8'd0);
    repeat (20) tick();
    show("d412_tenths", 4'b1110, 7'b0000001, 1'b1);
    show("d412_ones",   4'b1101, 7'b0010010, 1'b0);
    show("d412_tens",   4'b1011, 7'b1001111, 1'b1);
    show("d412_min",    4'b0111, 7'b1001100, 1'b1);

    // Reset and lap together: reset wins.
    reset = 1'b0; lap = 1'b1;
    tick();
    chk_reset_pins("reset_lap");
    lap = 1'b0;
    tick();
    chk_reset_pins("reset_after");
    reset = 1'b1;

    // 0:05.2, leading zeros blanked only when enabled.
    minute = 4'd0; second = 6'd5; float_second = 4'd2;
    repeat (20) tick();
    show("d005_tenths", 4'b1110, 7'b0010010, 1'b1);
    show("d005_ones",   4'b1101, 7'b0100100, 1'b0);
`ifdef STOPWATCH_LEAD_BLANK_EN
    show("d005_tens",   4'b1011, 7'b1111111, 1'b1);
    show("d005_min",    4'b0111, 7'b1111111, 1'b1);
`else
    show("d005_tens",   4'b1011, 7'b0000001, 1'b1);
    show("d005_min",    4'b0111, 7'b0000001, 1'b1);
`endif

    // Illegal minute shows a dash; seconds-tens no longer blanked.
    minute = 4'd10;
    repeat (20) tick();
    show("dash_min",  4'b0111, 7'b1111110, 1'b1);
    show("dash_tens", 4'b1011, 7'b0000001, 1'b1);

    // Out-of-range seconds 63 decode as 6/3 with no wrap.
    minute = 4'd1; second = 6'd63; float_second = 4'd9;
    repeat (20) tick();
    show("s63_tens",   4'b1011, 7'b0100000, 1'b1);
    show("s63_ones",   4'b1101, 7'b0000110, 1'b0);
    show("s63_tenths", 4'b1110, 7'b0000100, 1'b1);
    show("s63_min",    4'b0111, 7'b1001111, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
